// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache refill paths, the arbiter and main memory.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (caches plus memory) driving the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    // I-cache side
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;

    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;

    // Main memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-sized memory port between the
// I-cache and D-cache refill paths. A granted request is captured in
// registers so memory sees stable strobes/address/data until it completes;
// each completion is followed by one dead cycle before the next grant.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_d;      // 1 when the D-cache held the port last
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_d;
    logic              w_pick_i;
    logic              w_grant;
    logic              w_sel_write;
    logic              w_owner_busy;
    logic              w_done;

    assign w_i_req  = bus.i_read | bus.i_write;
    assign w_d_req  = bus.d_read | bus.d_write;

    // D wins when it is alone, or when both ask and I owned the port last.
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
    assign w_pick_i = w_i_req & ~w_pick_d;
    assign w_grant  = (r_state == IDLE) & (w_pick_i | w_pick_d);

    // Write has priority over read when a requester raises both.
    assign w_sel_write = w_pick_d ? bus.d_write : bus.i_write;

    // Completion only counts while someone owns the port and not under reset,
    // so an abandoned transaction never produces a ready pulse.
    assign w_owner_busy = (r_state == GRANT_I) | (r_state == GRANT_D);
    assign w_done       = rst_n & w_owner_busy & bus.mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: arbitrate in IDLE, wait for memory in GRANT, one dead cycle after
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_state_next = GRANT_D;
                end else if (w_pick_i) begin
                    w_state_next = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.mem_ready) begin
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request on grant; drop the strobes on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_d    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else if (w_grant) begin
            r_last_d    <= w_pick_d;
            r_mem_write <= w_sel_write;
            r_mem_read  <= ~w_sel_write;
            r_addr      <= w_pick_d ? bus.d_addr  : bus.i_addr;
            r_wdata     <= w_pick_d ? bus.d_wdata : bus.i_wdata;
        end else if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    // Response routed only to the current owner; the other side sees zeros.
    assign bus.i_ready = w_done & (r_state == GRANT_I);
    assign bus.d_ready = w_done & (r_state == GRANT_D);
    assign bus.i_rdata = bus.i_ready ? bus.mem_rdata : '0;
    assign bus.d_rdata = bus.d_ready ? bus.mem_rdata : '0;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between the instruction-cache refill path and the data-cache refill/write-back path. It sits between the two caches and the slow main memory. It serialises their line-sized transactions with round-robin priority and latches each granted request so the memory sees stable signals. It returns `mem_rdata`/`mem_ready` only to the owning requester.

## Interface
- `ADDR_W`, default 28: line address width.
- `LINE_W`, default 128: line data width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_read`  in  1  I-cache line read request, held until `i_ready`.
- `i_write`  in  1  I-cache write request; normally 0, supported for symmetry.
- `i_addr`  in  ADDR_W  I-cache line address.
- `i_wdata`  in  LINE_W  I-cache write data.
- `i_rdata`  out  LINE_W  read data returned to the I-cache.
- `i_ready`  out  1  one-cycle completion pulse to the I-cache.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: D-cache equivalents, same widths and directions as the I-cache ports.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory line address.
- `mem_wdata`  out  LINE_W  memory write data.
- `mem_rdata`  in  LINE_W  memory read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion pulse.

## Operation
- **States:**
  - IDLE: no transaction.
  - GRANT_I: I-cache owns the memory port.
  - GRANT_D: D-cache owns the memory port.
  - RELEASE: one dead cycle after each completion.
- **Pending requests:** `i_req = i_read|i_write`, `d_req = d_read|d_write`.
- **IDLE arbitration:**
  - Only `d_req` pending → GRANT_D.
  - Only `i_req` pending → GRANT_I.
  - Both pending → grant the requester that is not `last_owner`, then update `last_owner`.
  - `last_owner` resets to I, so the first contended grant goes to D.
- **On grant, latch into registers:**
  - operation: write if the requester's write is high, else read. Read and write both high from one requester counts as a write.
  - address.
  - write data.
- **While in GRANT_x:**
  - `mem_read`/`mem_write`, `mem_addr` and `mem_wdata` come from the latched registers only. Requester input changes are ignored.
  - The other requester sees `x_ready` = 0 and `x_rdata` = 0.
- **Completion:** `mem_ready` high in GRANT_x:
  - `x_ready` = 1 combinationally in the same cycle, and `x_rdata = mem_rdata`.
  - Next state is RELEASE.
- **RELEASE:**
  - Memory strobes are 0 and no new grant is made.
  - The requester drops its request during this cycle; a stale request is never re-granted.
  - Next state is IDLE.
- `mem_ready` in IDLE or RELEASE is ignored and produces no `x_ready`.
- Address arithmetic: none; addresses pass through unchanged at ADDR_W bits.

## Timing
- **Reset values:**
  - Outputs: `mem_read`/`mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0, `i_ready`/`d_ready` = 0, `i_rdata`/`d_rdata` = 0.
  - Internal: state = IDLE, `last_owner` = I.
- **Grant latency:** request first high at cycle t in IDLE → memory strobe high at t+1. Memory outputs are registered.
- **Completion:** `mem_ready` at cycle k → `x_ready` at cycle k (combinational), RELEASE at k+1, IDLE at k+2.
- **Earliest next grant:** evaluated at k+2, strobe at k+3. Back-to-back transactions have a minimum of 2 idle memory cycles between them.
- **`mem_ready` on the grant cycle:** if it is high in the first GRANT cycle, the transaction completes that cycle. Zero-wait memory is legal.
- **Request glitch:** a request raised and dropped within IDLE before the edge is not granted. Only the value sampled at the edge matters.
- **Reset mid-transaction:** the transaction is abandoned, all outputs return to reset values at the next edge, and no `x_ready` is produced. Memory is reset together with the arbiter.
- **Starvation bound:** with both requesters continuously active, grants strictly alternate D, I, D, I…

## Test plan
- **Single I read, memory ready after 3 cycles:** `i_read`=1, `i_addr`=0x0000123 at t → `mem_read`=1 and `mem_addr`=0x0000123 from t+1; `mem_ready` at t+4 with `mem_rdata`=0xDEADBEEF_… → `i_ready`=1 and `i_rdata`=that value at t+4; `d_ready` stays 0; `mem_read`=0 at t+5.
- **Contention from reset:** `i_read` and `d_read` both asserted at t → D granted first; after D completes and is released, I is granted; a third contended round goes to D again.
- **D write-back then refill:** `d_write`=1, `d_addr`=0x00000A0, `d_wdata`=0x1111…; `d_addr` is changed mid-transaction → `mem_write`=1 and `mem_addr` stay 0x00000A0 for the whole transaction. After `d_ready`, `d_read` at 0x00000B0 → `mem_read` from the 2nd cycle after RELEASE.
- **Zero-wait memory:** `mem_ready` tied high → each transaction's grant cycle completes it; `i_ready` pulses every 3rd cycle with a continuous `i_read`.
- **Spurious `mem_ready` in IDLE:** `mem_ready`=1 with no owner → `i_ready`=`d_ready`=0 and the state stays IDLE.
- **Reset mid-transaction:** `rst_n`=0 during GRANT_D → next edge gives `mem_read`=`mem_write`=0 and IDLE; `mem_ready` arriving later gives no `d_ready`.
